mem_responder: RTL and testbench
================================

# mem_responder

Word-addressed memory responder answering the far end of the CPU's memory-access path. It accepts one read or write request at a time over a valid/ready handshake, models configurable wait states, performs the access, and returns a response over a second valid/ready handshake. It replaces the zero-latency instruction/data memory when the multi-cycle core is exercised against slow or stalling memory, and flags misaligned or out-of-range accesses.

## Interface
- DEPTH_WORDS, 256: number of 32-bit words stored; power of two, ≥ 4.
- LATENCY, 2: wait-state cycles between acceptance and the access/response; range 0–15.
- clk  in  1  single clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept; high only in IDLE.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  32  byte address.
- req_wdata  in  32  write data.
- rsp_valid  out  1  response present; held until taken.
- rsp_ready  in  1  requester takes response.
- rsp_rdata  out  32  read data; 0 for writes and errors.
- rsp_err  out  1  access was misaligned or out of range.
- busy  out  1  high in WAIT or RESP.

## Operation
- States: IDLE, WAIT, RESP.
- IDLE: req_ready=1. On req_valid at an edge, latch write, addr, wdata; if LATENCY=0 perform access and go RESP, else load wait counter with LATENCY and go WAIT.
- WAIT: counter decrements each edge; on the edge where counter==1, perform access and go RESP. req_valid ignored.
- RESP: rsp_valid=1, rsp_rdata/rsp_err stable. On rsp_ready at an edge go IDLE. No new request is accepted in the same edge the response is taken.
- Access: word index = addr[31:2]. Error if addr[1:0]≠0 or addr[31:2] ≥ DEPTH_WORDS; on error no array read or write, rsp_err=1, rsp_rdata=0.
- Read: rsp_rdata = stored word at access time. Write: stored word updated at access edge; rsp_rdata=0, rsp_err=0.
- Request signals after acceptance do not affect the transaction; all fields come from the latched copy.

## Timing
- Reset: state IDLE, counter 0, latched fields 0, all storage words 0; outputs req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0.
- Request accepted at edge k ⇒ access at edge k+LATENCY, rsp_valid high from edge k+LATENCY until the edge where rsp_ready is sampled high.
- rsp_ready held high: one transaction per LATENCY+2 cycles; next req_ready high the cycle after the response edge.
- rsp_ready high while rsp_valid low: ignored.
- Reset mid-operation (WAIT or RESP): transaction discarded; a write not yet performed is never performed; storage cleared regardless.
- Reset and req_valid in same edge: reset wins, request not accepted.
- Read after write to same word: read returns written value (write committed at its access edge).
- Highest valid address 4·DEPTH_WORDS−4 succeeds; 4·DEPTH_WORDS errors.

## Structure
- Package mem_resp_pkg: state enum (IDLE, WAIT, RESP), WORD_W=32, counter width constant (4 bits).
- Sub-module mem_word_array: DEPTH_WORDS×32 storage with synchronous reset-clear, one write port, one combinational read port; responder owns the FSM, counter, latches, and error decode.

## Test plan
- LATENCY=2: write 0xDEADBEEF to 0x10, take response immediately → rsp_valid high 2 edges after accept, rsp_err=0, rsp_rdata=0; then read 0x10 → rsp_rdata=0xDEADBEEF.
- LATENCY=0: read 0x0 after reset → rsp_valid the cycle after accept, rsp_rdata=0, busy=1 for one cycle.
- Backpressure: read with rsp_ready low for 5 cycles → rsp_valid and rsp_rdata stable all 5 cycles, req_ready=0 throughout; new req_valid during that time not accepted.
- Errors: read 0x13 (misaligned) and 0x400 with DEPTH_WORDS=256 (out of range) → rsp_err=1, rsp_rdata=0; write to 0x3FC succeeds and reads back.
- Reset in WAIT during write of 0x12345678 to 0x20 → outputs return to reset values next cycle; subsequent read of 0x20 returns 0.
- Request fields changed after acceptance (addr 0x20→0x24) → access uses 0x20.

Source files
------------

// File: rtl/mem_responder_pkg.sv
// Shared types for the word-addressed memory responder: FSM states,
// latched request layout and the address error decode.
package mem_resp_pkg;

    localparam int WORD_W = 32;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic              write;
        logic [31:0]       addr;
        logic [WORD_W-1:0] wdata;
    } req_t;

    // Byte address must be word aligned and index inside the array.
    function automatic logic addr_err(input logic [31:0] addr, input logic [31:0] depth);
        return (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= depth);
    endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Request/response handshake bundle between a requester (master) and the
// memory responder (slave).
interface mem_responder_if;
    import mem_resp_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [31:0]       req_addr;
    logic [WORD_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [WORD_W-1:0] rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/mem_word_array.sv
// Purpose: DEPTH_WORDS x 32 storage, one write port, one combinational read port.
// Latency: write lands at the clock edge; read is same-cycle combinational.
// Backpressure: none; caller gates writes. Reset clears every word.
module mem_word_array
    import mem_resp_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    localparam int AW = $clog2(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [WORD_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/mem_responder.sv
// Purpose: single-outstanding word memory responder with wait states and error flagging.
// Latency: access and rsp_valid LATENCY edges after acceptance (0 = next cycle).
// Backpressure: response held stable until rsp_ready; no request accepted outside IDLE.
module mem_responder
    import mem_resp_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic            clk,
    input  logic            reset,
    mem_responder_if.slave  bus,
    output logic            busy
);

    localparam int AW = $clog2(DEPTH_WORDS);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    req_t              lat_q;
    logic [WORD_W-1:0] rdata_q;
    logic              err_q;

    req_t              in_req;
    req_t              acc_req;
    logic              accept;
    logic              do_access;
    logic              acc_err;
    logic [AW-1:0]     acc_idx;
    logic              arr_we;
    logic [WORD_W-1:0] arr_rdata;

    always_comb begin
        in_req.write = bus.req_write;
        in_req.addr  = bus.req_addr;
        in_req.wdata = bus.req_wdata;
    end

    assign accept = (state_q == IDLE) && bus.req_valid;

    // With zero wait states the access uses the live request in the accepting
    // cycle; otherwise it always comes from the latched copy.
    assign do_access = (accept && (LATENCY == 0)) ||
                       ((state_q == WAIT) && (cnt_q == CNT_W'(1)));
    assign acc_req   = (state_q == IDLE) ? in_req : lat_q;
    assign acc_err   = addr_err(acc_req.addr, 32'(DEPTH_WORDS));
    assign acc_idx   = acc_req.addr[AW+1:2];
    assign arr_we    = do_access && acc_req.write && !acc_err;

    mem_word_array #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_array (
        .clk   (clk),
        .reset (reset),
        .we    (arr_we),
        .waddr (acc_idx),
        .wdata (acc_req.wdata),
        .raddr (acc_idx),
        .rdata (arr_rdata)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    if (LATENCY == 0) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_W'(LATENCY);
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            lat_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                lat_q <= in_req;
            end
            if (do_access) begin
                err_q   <= acc_err;
                rdata_q <= (acc_req.write || acc_err) ? '0 : arr_rdata;
            end
        end
    end

    assign bus.req_ready = (state_q == IDLE);
    assign bus.rsp_valid = (state_q == RESP);
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;
    assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench: dut 0 runs with LATENCY=2, dut 1 with LATENCY=0, both 256 words.
module tb_mem_responder;
    import mem_resp_pkg::*;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_responder_if bus0 ();
    mem_responder_if bus1 ();

    logic [1:0]  vld, wr_d, rr;
    logic [31:0] addr_d [2];
    logic [31:0] wdat_d [2];
    logic [1:0]  rdy, rv, rerr, busy;
    logic [31:0] rdat [2];

    assign bus0.req_valid = vld[0];
    assign bus0.req_write = wr_d[0];
    assign bus0.req_addr  = addr_d[0];
    assign bus0.req_wdata = wdat_d[0];
    assign bus0.rsp_ready = rr[0];
    assign bus1.req_valid = vld[1];
    assign bus1.req_write = wr_d[1];
    assign bus1.req_addr  = addr_d[1];
    assign bus1.req_wdata = wdat_d[1];
    assign bus1.rsp_ready = rr[1];

    assign rdy[0]  = bus0.req_ready;
    assign rv[0]   = bus0.rsp_valid;
    assign rdat[0] = bus0.rsp_rdata;
    assign rerr[0] = bus0.rsp_err;
    assign rdy[1]  = bus1.req_ready;
    assign rv[1]   = bus1.rsp_valid;
    assign rdat[1] = bus1.rsp_rdata;
    assign rerr[1] = bus1.rsp_err;

    mem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) u_dut0 (
        .clk(clk), .reset(reset), .bus(bus0), .busy(busy[0])
    );
    mem_responder #(.DEPTH_WORDS(256), .LATENCY(0)) u_dut1 (
        .clk(clk), .reset(reset), .bus(bus1), .busy(busy[1])
    );

    int checks = 0;
    int errors = 0;
    int lat_of [2] = '{2, 0};
    logic [31:0] mm [2][256];
    exp_t sb [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 256; i++) mm[d][i] = '0;
        sb.delete();
    endtask

    task automatic check_idle_outputs(input int d, input string tag);
        check({tag, "_req_ready"}, {31'd0, rdy[d]}, 32'd1);
        check({tag, "_rsp_valid"}, {31'd0, rv[d]}, 32'd0);
        check({tag, "_busy"},      {31'd0, busy[d]}, 32'd0);
    endtask

    // One full transaction; stall = cycles of rsp_ready low while valid,
    // chg = keep req_valid high and scramble request fields after acceptance.
    task automatic txn(input int d, input logic wr, input logic [31:0] a,
                       input logic [31:0] wd, input int stall, input logic chg);
        exp_t e;
        int n;
        logic err;
        logic [31:0] held;
        n = 0;
        while (!rdy[d] && n < 50) begin @(posedge clk); #1; n++; end
        check("req_ready_before", {31'd0, rdy[d]}, 32'd1);
        err     = (a[1:0] != 2'b00) || (a[31:2] >= 30'd256);
        e.err   = err;
        e.rdata = (wr || err) ? 32'd0 : mm[d][a[9:2]];
        if (wr && !err) mm[d][a[9:2]] = wd;
        sb.push_back(e);
        vld[d] = 1'b1; wr_d[d] = wr; addr_d[d] = a; wdat_d[d] = wd;
        @(posedge clk); #1;
        if (chg) begin
            addr_d[d] = a + 32'd4; wdat_d[d] = ~wd; wr_d[d] = ~wr;
        end else begin
            vld[d] = 1'b0;
        end
        check("busy_after_accept", {31'd0, busy[d]}, 32'd1);
        n = 0;
        while (!rv[d] && n < 50) begin
            check("req_ready_wait", {31'd0, rdy[d]}, 32'd0);
            @(posedge clk); #1; n++;
        end
        check("rsp_latency", 32'(n), 32'(lat_of[d]));
        held = rdat[d];
        for (int i = 0; i < stall; i++) begin
            check("stall_rsp_valid", {31'd0, rv[d]}, 32'd1);
            check("stall_rdata", rdat[d], held);
            check("stall_req_ready", {31'd0, rdy[d]}, 32'd0);
            @(posedge clk); #1;
        end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("rsp_rdata", rdat[d], e.rdata);
            check("rsp_err", {31'd0, rerr[d]}, {31'd0, e.err});
        end else begin
            check("scoreboard_empty", 32'(sb.size()), 32'd1);
        end
        rr[d] = 1'b1;
        @(posedge clk); #1;
        rr[d] = 1'b0; vld[d] = 1'b0; wr_d[d] = 1'b0;
        check_idle_outputs(d, "after_rsp");
    endtask

    initial begin
        vld = '0; wr_d = '0; rr = '0;
        addr_d = '{32'd0, 32'd0}; wdat_d = '{32'd0, 32'd0};
        reset = 1'b1;
        clear_model();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        for (int d = 0; d < 2; d++) begin
            check_idle_outputs(d, "reset");
            check("reset_rdata", rdat[d], 32'd0);
            check("reset_err", {31'd0, rerr[d]}, 32'd0);
        end

        // rsp_ready with nothing pending must not disturb the idle responder
        rr[0] = 1'b1;
        repeat (3) @(posedge clk);
        #1 rr[0] = 1'b0;
        check_idle_outputs(0, "stray_rsp_ready");

        txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 0, 1'b0);
        txn(0, 1'b0, 32'h10, 32'h0, 0, 1'b0);
        txn(1, 1'b0, 32'h0, 32'h0, 0, 1'b0);
        txn(1, 1'b1, 32'h44, 32'hA5A5_0001, 0, 1'b0);
        txn(1, 1'b0, 32'h44, 32'h0, 0, 1'b0);

        // backpressure with a competing request held on the bus
        txn(0, 1'b0, 32'h10, 32'h0, 5, 1'b1);
        txn(1, 1'b0, 32'h44, 32'h0, 5, 1'b1);

        txn(0, 1'b0, 32'h13, 32'h0, 0, 1'b0);
        txn(0, 1'b0, 32'h400, 32'h0, 0, 1'b0);
        txn(1, 1'b1, 32'h401, 32'h1111_2222, 0, 1'b0);
        txn(0, 1'b1, 32'h3FC, 32'hCAFE_F00D, 0, 1'b0);
        txn(0, 1'b0, 32'h3FC, 32'h0, 0, 1'b0);

        // fields scrambled after acceptance: write lands at 0x20 only
        txn(0, 1'b1, 32'h20, 32'h0BAD_C0DE, 0, 1'b1);
        txn(0, 1'b0, 32'h24, 32'h0, 0, 1'b0);
        txn(0, 1'b0, 32'h20, 32'h0, 0, 1'b0);

        // reset while a write waits
        vld[0] = 1'b1; wr_d[0] = 1'b1; addr_d[0] = 32'h20; wdat_d[0] = 32'h12345678;
        @(posedge clk); #1;
        vld[0] = 1'b0;
        check("wait_busy", {31'd0, busy[0]}, 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        clear_model();
        check_idle_outputs(0, "mid_reset");
        check("mid_reset_rdata", rdat[0], 32'd0);
        check("mid_reset_err", {31'd0, rerr[0]}, 32'd0);
        repeat (4) @(posedge clk);
        #1 check("mid_reset_no_rsp", {31'd0, rv[0]}, 32'd0);
        txn(0, 1'b0, 32'h20, 32'h0, 0, 1'b0);
        txn(0, 1'b0, 32'h10, 32'h0, 0, 1'b0);

        // reset and request on the same edge: reset wins
        vld[1] = 1'b1; wr_d[1] = 1'b0; addr_d[1] = 32'h0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; vld[1] = 1'b0;
        clear_model();
        check_idle_outputs(1, "reset_vs_req");
        txn(1, 1'b0, 32'h44, 32'h0, 0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1);
    end

endmodule
